// File: rtl/regfile_fwd_if.sv
// Register-file bus: MEM/WB writeback, EX/MEM forwarding triples, two ID read ports and stall request.
// The master side is pipeline control and the ID stage; the slave side is regfile_fwd.
interface regfile_fwd_if #(
    parameter int XLEN = 32
);
    logic            we;
    logic [4:0]      waddr;
    logic [XLEN-1:0] wdata;
    logic            ex_wreg;
    logic [4:0]      ex_wd;
    logic [XLEN-1:0] ex_wdata;
    logic            ex_is_load;
    logic            mem_wreg;
    logic [4:0]      mem_wd;
    logic [XLEN-1:0] mem_wdata;
    logic            re1;
    logic            re2;
    logic [4:0]      raddr1;
    logic [4:0]      raddr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            stallreq;

    modport master (
        output we, waddr, wdata,
        output ex_wreg, ex_wd, ex_wdata, ex_is_load,
        output mem_wreg, mem_wd, mem_wdata,
        output re1, re2, raddr1, raddr2,
        input  rdata1, rdata2, stallreq
    );

    modport slave (
        input  we, waddr, wdata,
        input  ex_wreg, ex_wd, ex_wdata, ex_is_load,
        input  mem_wreg, mem_wd, mem_wdata,
        input  re1, re2, raddr1, raddr2,
        output rdata1, rdata2, stallreq
    );
endinterface

// File: rtl/regfile_fwd.sv
// RV32I integer register file (x1..x31) with two combinational read ports, EX/MEM forwarding and load-use stall.
// Define REGFILE_FWD_EN to forward EX/MEM results; without it any EX/MEM match stalls instead.
module regfile_fwd #(
    parameter int NREG = 32,
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    regfile_fwd_if.slave  rf
);

    localparam int AW = 5;

    // x0 is not stored; index 0 never reaches the array because the read path returns 0 first.
    logic [XLEN-1:0] regs_reg [1:NREG-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < NREG; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (rf.we && rf.waddr != '0) begin
            regs_reg[rf.waddr] <= rf.wdata;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : port_g
            logic            re_p;
            logic [AW-1:0]   raddr_p;
            logic [XLEN-1:0] rdata_p;
            logic            hazard_p;

            assign re_p    = (gi == 0) ? rf.re1    : rf.re2;
            assign raddr_p = (gi == 0) ? rf.raddr1 : rf.raddr2;

            // Youngest producer wins: EX, then MEM, then the writeback in flight, then the array.
            always_comb begin
                rdata_p  = '0;
                hazard_p = 1'b0;
                if (!rst || !re_p || raddr_p == '0) begin
                    rdata_p  = '0;
                end else if (rf.ex_wreg && rf.ex_wd == raddr_p) begin
`ifdef REGFILE_FWD_EN
                    if (rf.ex_is_load) begin
                        hazard_p = 1'b1;
                    end else begin
                        rdata_p = rf.ex_wdata;
                    end
`else
                    hazard_p = 1'b1;
`endif
                end else if (rf.mem_wreg && rf.mem_wd == raddr_p) begin
`ifdef REGFILE_FWD_EN
                    rdata_p = rf.mem_wdata;
`else
                    hazard_p = 1'b1;
`endif
                end else if (rf.we && rf.waddr == raddr_p) begin
                    rdata_p = rf.wdata;
                end else begin
                    rdata_p = regs_reg[raddr_p];
                end
            end
        end
    endgenerate

`ifndef REGFILE_FWD_EN
    // Forwarded data is not consumed when forwarding is compiled out.
    logic unused_fwd_data;
    assign unused_fwd_data = ^{rf.ex_wdata, rf.mem_wdata, rf.ex_is_load};
`endif

    assign rf.rdata1   = port_g[0].rdata_p;
    assign rf.rdata2   = port_g[1].rdata_p;
    assign rf.stallreq = port_g[0].hazard_p | port_g[1].hazard_p;

endmodule

// File: tb/tb_regfile_fwd.sv
// Self-checking bench for regfile_fwd: vector table, corner-case sequences and randomized model comparison.
// Expectations follow REGFILE_FWD_EN when the macro is defined for the build.
module tb_regfile_fwd;

`ifdef REGFILE_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    regfile_fwd_if #(.XLEN(32)) rf_bus ();

    regfile_fwd #(.NREG(32), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        re1, re2;
        logic [4:0]  ra1, ra2;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        ex_wreg;
        logic [4:0]  ex_wd;
        logic [31:0] ex_wdata;
        logic        ex_ld;
        logic        mem_wreg;
        logic [4:0]  mem_wd;
        logic [31:0] mem_wdata;
        logic [31:0] e1, e2;
        logic        es;
    } vec_t;

    vec_t        vecs [9];
    logic [31:0] model_mem [32];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        rf_bus.we = 0; rf_bus.waddr = 0; rf_bus.wdata = 0;
        rf_bus.ex_wreg = 0; rf_bus.ex_wd = 0; rf_bus.ex_wdata = 0; rf_bus.ex_is_load = 0;
        rf_bus.mem_wreg = 0; rf_bus.mem_wd = 0; rf_bus.mem_wdata = 0;
        rf_bus.re1 = 0; rf_bus.re2 = 0; rf_bus.raddr1 = 0; rf_bus.raddr2 = 0;
    endtask

    // Advance one clock; the model commits the writeback that was presented this cycle.
    task automatic tick();
        @(posedge clk);
        if (rst && rf_bus.we && rf_bus.waddr != 0) model_mem[rf_bus.waddr] = rf_bus.wdata;
        #1;
    endtask

    // Reference model: returns {hazard, data} for one read port from the resolution rules.
    function automatic logic [32:0] model_port(input logic re, input logic [4:0] ra);
        if (!rst || !re || ra == 0) return 33'd0;
        if (rf_bus.ex_wreg && rf_bus.ex_wd == ra) begin
            if (!FWD || rf_bus.ex_is_load) return {1'b1, 32'd0};
            return {1'b0, rf_bus.ex_wdata};
        end
        if (rf_bus.mem_wreg && rf_bus.mem_wd == ra)
            return FWD ? {1'b0, rf_bus.mem_wdata} : {1'b1, 32'd0};
        if (rf_bus.we && rf_bus.waddr == ra) return {1'b0, rf_bus.wdata};
        return {1'b0, model_mem[ra]};
    endfunction

    initial begin
        logic [32:0] p1, p2;
        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) model_mem[i] = 0;
        idle_inputs();

        // Reset state: outputs forced to 0 and no stall even with a load hazard present.
        rst = 1'b0;
        rf_bus.re1 = 1; rf_bus.raddr1 = 5; rf_bus.re2 = 1; rf_bus.raddr2 = 5;
        rf_bus.ex_wreg = 1; rf_bus.ex_wd = 5; rf_bus.ex_is_load = 1;
        #2;
        check("reset_rdata1", rf_bus.rdata1, 32'd0);
        check("reset_rdata2", rf_bus.rdata2, 32'd0);
        check("reset_stall", {31'd0, rf_bus.stallreq}, 32'd0);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        vecs[0] = '{1,1, 0,0, 1,0,32'hFFFF_FFFF, 1,0,32'h0,0, 0,0,32'h0, 32'h0, 32'h0, 0};
        vecs[1] = '{1,1, 7,7, 1,7,32'hC, 1,7,32'hA,0, 1,7,32'hB,
                    FWD ? 32'hA : 32'h0, FWD ? 32'hA : 32'h0, !FWD};
        vecs[2] = '{1,1, 7,7, 0,0,32'h0, 0,0,32'h0,0, 0,0,32'h0, 32'hC, 32'hC, 0};
        vecs[3] = '{1,1, 9,7, 1,9,32'h11, 0,0,32'h0,0, 0,0,32'h0, 32'h11, 32'hC, 0};
        vecs[4] = '{1,1, 9,9, 1,9,32'h22, 0,0,32'h0,0, 0,0,32'h0, 32'h22, 32'h22, 0};
        vecs[5] = '{1,1, 9,9, 0,0,32'h0, 0,0,32'h0,0, 0,0,32'h0, 32'h22, 32'h22, 0};
        vecs[6] = '{0,0, 7,7, 0,0,32'h0, 1,7,32'h0,1, 0,0,32'h0, 32'h0, 32'h0, 0};
        vecs[7] = '{1,1, 9,7, 0,0,32'h0, 0,0,32'h0,0, 1,9,32'h99,
                    FWD ? 32'h99 : 32'h0, 32'hC, !FWD};
        vecs[8] = '{1,1, 9,7, 0,0,32'h0, 1,7,32'h77,0, 0,0,32'h0,
                    32'h22, FWD ? 32'h77 : 32'h0, !FWD};

        for (int v = 0; v < 9; v++) begin
            rf_bus.re1 = vecs[v].re1; rf_bus.re2 = vecs[v].re2;
            rf_bus.raddr1 = vecs[v].ra1; rf_bus.raddr2 = vecs[v].ra2;
            rf_bus.we = vecs[v].we; rf_bus.waddr = vecs[v].waddr; rf_bus.wdata = vecs[v].wdata;
            rf_bus.ex_wreg = vecs[v].ex_wreg; rf_bus.ex_wd = vecs[v].ex_wd;
            rf_bus.ex_wdata = vecs[v].ex_wdata; rf_bus.ex_is_load = vecs[v].ex_ld;
            rf_bus.mem_wreg = vecs[v].mem_wreg; rf_bus.mem_wd = vecs[v].mem_wd;
            rf_bus.mem_wdata = vecs[v].mem_wdata;
            #2;
            $display("vec %0d: r1=0x%08h r2=0x%08h stall=%0b", v, rf_bus.rdata1, rf_bus.rdata2, rf_bus.stallreq);
            check($sformatf("vec%0d_rdata1", v), rf_bus.rdata1, vecs[v].e1);
            check($sformatf("vec%0d_rdata2", v), rf_bus.rdata2, vecs[v].e2);
            check($sformatf("vec%0d_stall", v), {31'd0, rf_bus.stallreq}, {31'd0, vecs[v].es});
            tick();
        end

        // Load-use: one stall cycle, then the bubbled EX lets MEM supply the value.
        idle_inputs();
        rf_bus.ex_wreg = 1; rf_bus.ex_is_load = 1; rf_bus.ex_wd = 3; rf_bus.ex_wdata = 32'hDEAD;
        rf_bus.re1 = 1; rf_bus.raddr1 = 9; rf_bus.re2 = 1; rf_bus.raddr2 = 3;
        #2;
        $display("loaduse c0: r1=0x%08h r2=0x%08h stall=%0b", rf_bus.rdata1, rf_bus.rdata2, rf_bus.stallreq);
        check("loaduse_stall", {31'd0, rf_bus.stallreq}, 32'd1);
        check("loaduse_rdata2", rf_bus.rdata2, 32'd0);
        check("loaduse_rdata1", rf_bus.rdata1, 32'h22);
        tick();
        rf_bus.ex_wreg = 0; rf_bus.ex_is_load = 0;
        rf_bus.mem_wreg = 1; rf_bus.mem_wd = 3; rf_bus.mem_wdata = 32'h55;
        #2;
        $display("loaduse c1: r2=0x%08h stall=%0b", rf_bus.rdata2, rf_bus.stallreq);
        check("loaduse_release_stall", {31'd0, rf_bus.stallreq}, FWD ? 32'd0 : 32'd1);
        check("loaduse_release_rdata2", rf_bus.rdata2, FWD ? 32'h55 : 32'h0);
        tick();

        // Asynchronous reset between edges clears the array without a clock.
        idle_inputs();
        rf_bus.we = 1; rf_bus.waddr = 5; rf_bus.wdata = 32'h1234;
        tick();
        rf_bus.we = 0;
        rf_bus.re1 = 1; rf_bus.raddr1 = 5;
        #1;
        check("reset_pre_x5", rf_bus.rdata1, 32'h1234);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model_mem[i] = 0;
        #1;
        check("reset_async_x5", rf_bus.rdata1, 32'd0);
        rst = 1'b1;
        #1;
        $display("reset pulse: x5=0x%08h", rf_bus.rdata1);
        check("reset_cleared_x5", rf_bus.rdata1, 32'd0);
        tick();

        // Randomized traffic on a narrow address range to force collisions.
        for (int c = 0; c < 300; c++) begin
            rf_bus.re1 = ($urandom_range(0, 7) != 0);
            rf_bus.re2 = ($urandom_range(0, 7) != 0);
            rf_bus.raddr1 = 5'($urandom_range(0, 7));
            rf_bus.raddr2 = 5'($urandom_range(0, 7));
            rf_bus.we = $urandom_range(0, 1) == 1;
            rf_bus.waddr = 5'($urandom_range(0, 7));
            rf_bus.wdata = $urandom;
            rf_bus.ex_wreg = $urandom_range(0, 2) == 0;
            rf_bus.ex_wd = 5'($urandom_range(0, 7));
            rf_bus.ex_wdata = $urandom;
            rf_bus.ex_is_load = $urandom_range(0, 3) == 0;
            rf_bus.mem_wreg = $urandom_range(0, 2) == 0;
            rf_bus.mem_wd = 5'($urandom_range(0, 7));
            rf_bus.mem_wdata = $urandom;
            #2;
            p1 = model_port(rf_bus.re1, rf_bus.raddr1);
            p2 = model_port(rf_bus.re2, rf_bus.raddr2);
            $display("rand %0d: r1=0x%08h r2=0x%08h stall=%0b", c, rf_bus.rdata1, rf_bus.rdata2, rf_bus.stallreq);
            check("rand_rdata1", rf_bus.rdata1, p1[31:0]);
            check("rand_rdata2", rf_bus.rdata2, p2[31:0]);
            check("rand_stall", {31'd0, rf_bus.stallreq}, {31'd0, p1[32] | p2[32]});
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
